alu_multiciclo: RTL and testbench

ALU_MULTICICLO -- requirements
Module: alu_multiciclo

---
 rtl/alu_multiciclo.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_multiciclo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle ALU with a valid/ready style handshake.
// Single-cycle operations finish on the accept edge; MUL (shift-add) and
// DIV (restoring) iterate one bit per clock for ANCHO cycles, and the last
// iteration edge also writes the result. Results are held until the
// consumer takes them with acepta_in.
module alu_multiciclo #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] operandoA,
    input  logic [ANCHO-1:0] operandoB,
    input  logic [3:0]       seleccion,
    input  logic             valido_in,
    output logic             listo,
    output logic [ANCHO-1:0] resultado,
    output logic [ANCHO-1:0] resultado_alto,
    output logic [3:0]       banderas,
    output logic             valido_out,
    input  logic             acepta_in
);

    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0]  ULTIMO    = CW'(ANCHO - 1);
    localparam logic [ANCHO:0] ANCHO_EXT = (ANCHO + 1)'(ANCHO);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        CALCULO = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic [ANCHO-1:0] alto_q, alto_d;
    logic [3:0]       flags_q, flags_d;

    // Operand latches and iteration registers; only meaningful outside LIBRE
    logic [ANCHO-1:0] a_q, a_d, b_q, b_d;
    logic [ANCHO-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             es_div_q, es_div_d;

    logic             acepta;
    logic             es_multi;
    logic [ANCHO-1:0] s_res;
    logic             s_c, s_v;
    logic [ANCHO-1:0] hi_n, lo_n;
    logic [ANCHO-1:0] f_res, f_alto;
    logic             f_c, f_v;

    assign acepta   = valido_in && (estado_q == LIBRE);
    assign es_multi = (seleccion == OP_MUL) || (seleccion == OP_DIV);

    // State register plus everything that must be cleared/aborted by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= LIBRE;
            cnt_q    <= '0;
            res_q    <= '0;
            alto_q   <= '0;
            flags_q  <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            alto_q   <= alto_d;
            flags_q  <= flags_d;
        end
    end

    // Operand capture and shift-add / restoring-division working registers
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        hi_q     <= hi_d;
        lo_q     <= lo_d;
        es_div_q <= es_div_d;
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            LIBRE:   if (valido_in) estado_d = es_multi ? CALCULO : ENTREGA;
            CALCULO: if (cnt_q == ULTIMO) estado_d = ENTREGA;
            ENTREGA: if (acepta_in) estado_d = LIBRE;
            default: estado_d = LIBRE;
        endcase
    end

    // Single-cycle operations, evaluated straight from the inputs at acceptance
    always_comb begin
        logic [ANCHO:0]          suma, resta;
        logic signed [ANCHO-1:0] a_s;
        logic                    fuera;
        suma  = {1'b0, operandoA} + {1'b0, operandoB};
        resta = {1'b0, operandoA} - {1'b0, operandoB};
        a_s   = operandoA;
        fuera = {1'b0, operandoB} >= ANCHO_EXT;
        s_res = suma[ANCHO-1:0];
        s_c   = suma[ANCHO];
        s_v   = (operandoA[ANCHO-1] == operandoB[ANCHO-1]) &&
                (suma[ANCHO-1] != operandoA[ANCHO-1]);
        case (seleccion)
            OP_ADD: ;
            OP_SUB: begin
                s_res = resta[ANCHO-1:0];
                s_c   = resta[ANCHO];
                s_v   = (operandoA[ANCHO-1] != operandoB[ANCHO-1]) &&
                        (resta[ANCHO-1] != operandoA[ANCHO-1]);
            end
            OP_AND: begin s_res = operandoA & operandoB; s_c = 1'b0; s_v = 1'b0; end
            OP_OR:  begin s_res = operandoA | operandoB; s_c = 1'b0; s_v = 1'b0; end
            OP_XOR: begin s_res = operandoA ^ operandoB; s_c = 1'b0; s_v = 1'b0; end
            OP_SLL: begin
                s_res = fuera ? '0 : (operandoA << operandoB);
                s_c   = 1'b0;
                s_v   = 1'b0;
            end
            OP_SRL: begin
                s_res = fuera ? '0 : (operandoA >> operandoB);
                s_c   = 1'b0;
                s_v   = 1'b0;
            end
            OP_SRA: begin
                s_res = fuera ? {ANCHO{operandoA[ANCHO-1]}} : (a_s >>> operandoB);
                s_c   = 1'b0;
                s_v   = 1'b0;
            end
            default: ; // unknown codes run as ADD
        endcase
    end

    // One iteration step of MUL (shift-add) or DIV (restoring), plus final flags
    always_comb begin
        logic [ANCHO:0] suma_m, r_sh, dif;
        suma_m = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        r_sh   = {hi_q, lo_q[ANCHO-1]};
        dif    = r_sh - {1'b0, b_q};
        if (es_div_q) begin
            if (r_sh >= {1'b0, b_q}) begin
                hi_n = dif[ANCHO-1:0];
                lo_n = {lo_q[ANCHO-2:0], 1'b1};
            end else begin
                hi_n = r_sh[ANCHO-1:0];
                lo_n = {lo_q[ANCHO-2:0], 1'b0};
            end
        end else begin
            hi_n = suma_m[ANCHO:1];
            lo_n = {suma_m[0], lo_q[ANCHO-1:1]};
        end

        f_res  = lo_n;
        f_alto = hi_n;
        f_c    = 1'b0;
        f_v    = 1'b0;
        if (es_div_q) begin
            // Divide by zero gets a fixed answer rather than the loop's output
            if (b_q == '0) begin
                f_res  = '1;
                f_alto = a_q;
                f_v    = 1'b1;
            end
        end else begin
            f_c = |hi_n;
            f_v = |hi_n;
        end
    end

    // Datapath register updates: capture on accept, iterate in CALCULO
    always_comb begin
        cnt_d    = cnt_q;
        res_d    = res_q;
        alto_d   = alto_q;
        flags_d  = flags_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        es_div_d = es_div_q;
        if (acepta) begin
            a_d      = operandoA;
            b_d      = operandoB;
            es_div_d = (seleccion == OP_DIV);
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = (seleccion == OP_DIV) ? operandoA : operandoB;
            if (!es_multi) begin
                res_d   = s_res;
                alto_d  = '0;
                flags_d = {s_res[ANCHO-1], (s_res == '0), s_c, s_v};
            end
        end else if (estado_q == CALCULO) begin
            hi_d = hi_n;
            lo_d = lo_n;
            if (cnt_q == ULTIMO) begin
                cnt_d   = '0;
                res_d   = f_res;
                alto_d  = f_alto;
                flags_d = {f_res[ANCHO-1], (f_res == '0), f_c, f_v};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Handshake outputs decoded from the state
    always_comb begin
        listo      = (estado_q == LIBRE);
        valido_out = (estado_q == ENTREGA);
    end

    assign resultado      = res_q;
    assign resultado_alto = alto_q;
    assign banderas       = flags_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Testbench for alu_multiciclo at ANCHO=4: table of hand-derived vectors,
// a reference-model random pass, and handshake/reset corner sequences.
module tb_alu_multiciclo;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, MUL = 4'b0010, DIV = 4'b0011;
    localparam logic [3:0] AND_ = 4'b0101, OR_ = 4'b0110, SLL = 4'b0111, SRL = 4'b1000;
    localparam logic [3:0] XOR_ = 4'b1001, SRA = 4'b1010;

    typedef struct {
        logic [3:0] res;
        logic [3:0] alto;
        logic [3:0] flags;
        int         lat;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        exp_t       e;
    } vec_t;

    logic       clk, rst_n;
    logic [3:0] operandoA, operandoB, seleccion;
    logic       valido_in, acepta_in;
    logic       listo, valido_out;
    logic [3:0] resultado, resultado_alto, banderas;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tabla[$];

    alu_multiciclo #(.ANCHO(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .operandoA(operandoA), .operandoB(operandoB), .seleccion(seleccion),
        .valido_in(valido_in), .listo(listo),
        .resultado(resultado), .resultado_alto(resultado_alto),
        .banderas(banderas), .valido_out(valido_out), .acepta_in(acepta_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk_e(input logic [3:0] r, h, f, input int l);
        exp_t e;
        e.res = r; e.alto = h; e.flags = f; e.lat = l;
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] a, b, s, r, h, f, input int l);
        vec_t v;
        v.a = a; v.b = b; v.sel = s; v.e = mk_e(r, h, f, l);
        return v;
    endfunction

    // Behavioural reference built from plain integer arithmetic
    function automatic exp_t modelo(input logic [3:0] a, b, s);
        exp_t e;
        int ia, ib, sa, sb_, t;
        logic [3:0] r;
        logic c, v;
        ia = int'(a); ib = int'(b);
        sa = int'($signed(a)); sb_ = int'($signed(b));
        e.alto = 4'd0; e.lat = 1; c = 1'b0; v = 1'b0;
        case (s)
            SUB: begin
                t = ia - ib; r = 4'(t); c = (ia < ib);
                v = ((sa - sb_) > 7) || ((sa - sb_) < -8);
            end
            MUL: begin
                t = ia * ib; r = 4'(t); e.alto = 4'(t >> 4);
                c = (t > 15); v = c; e.lat = 5;
            end
            DIV: begin
                e.lat = 5;
                if (ib == 0) begin r = 4'hF; e.alto = a; v = 1'b1; end
                else begin r = 4'(ia / ib); e.alto = 4'(ia % ib); end
            end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            SLL:  r = (ib >= 4) ? 4'd0 : 4'(ia << ib);
            SRL:  r = (ib >= 4) ? 4'd0 : 4'(ia >> ib);
            SRA:  r = 4'(sa >>> ib);
            default: begin
                t = ia + ib; r = 4'(t); c = (t > 15);
                v = ((sa + sb_) > 7) || ((sa + sb_) < -8);
            end
        endcase
        e.res = r;
        e.flags = {r[3], (r == 4'd0), c, v};
        return e;
    endfunction

    task automatic run_op(input logic [3:0] a, b, s, input exp_t e);
        logic [3:0] pr, ph, pf;
        bit   hold_ok;
        int   lat;
        exp_t got;
        @(negedge clk);
        chk("listo_before", 32'(listo), 32'd1);
        operandoA = a; operandoB = b; seleccion = s; valido_in = 1'b1;
        sb.push_back(e);
        pr = resultado; ph = resultado_alto; pf = banderas;
        @(posedge clk); #1;
        valido_in = 1'b0; operandoA = ~a; operandoB = ~b; seleccion = XOR_;
        lat = 1; hold_ok = 1'b1;
        while (!valido_out && lat < 20) begin
            if (resultado !== pr || resultado_alto !== ph || banderas !== pf || listo !== 1'b0)
                hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        got = sb.pop_front();
        chk($sformatf("lat op%0h a%0h b%0h", s, a, b), 32'(lat), 32'(got.lat));
        chk($sformatf("res op%0h a%0h b%0h", s, a, b), 32'(resultado), 32'(got.res));
        chk($sformatf("alto op%0h a%0h b%0h", s, a, b), 32'(resultado_alto), 32'(got.alto));
        chk($sformatf("flags op%0h a%0h b%0h", s, a, b), 32'(banderas), 32'(got.flags));
        if (got.lat > 1) chk("hold_in_calculo", 32'(hold_ok), 32'd1);
        @(negedge clk); acepta_in = 1'b1;
        @(posedge clk); #1; acepta_in = 1'b0;
        chk("listo_after_accept", 32'(listo), 32'd1);
        chk("vout_after_accept", 32'(valido_out), 32'd0);
    endtask

    initial begin
        exp_t got;
        bit   saw;
        rst_n = 1'b0; valido_in = 1'b0; acepta_in = 1'b0;
        operandoA = 4'd0; operandoB = 4'd0; seleccion = 4'd0;

        tabla.push_back(mk(4'b0111, 4'b1001, ADD,     4'b0000, 4'b0000, 4'b0110, 1));
        tabla.push_back(mk(4'b0011, 4'b0101, SUB,     4'b1110, 4'b0000, 4'b1010, 1));
        tabla.push_back(mk(4'b0111, 4'b1000, SUB,     4'b1111, 4'b0000, 4'b1011, 1));
        tabla.push_back(mk(4'b1101, 4'b1011, MUL,     4'b1111, 4'b1000, 4'b1011, 5));
        tabla.push_back(mk(4'b1110, 4'b0011, DIV,     4'b0100, 4'b0010, 4'b0000, 5));
        tabla.push_back(mk(4'b1001, 4'b0000, DIV,     4'b1111, 4'b1001, 4'b1001, 5));
        tabla.push_back(mk(4'b1000, 4'b0101, SRA,     4'b1111, 4'b0000, 4'b1000, 1));
        tabla.push_back(mk(4'b1100, 4'b1010, AND_,    4'b1000, 4'b0000, 4'b1000, 1));
        tabla.push_back(mk(4'b1100, 4'b1010, OR_,     4'b1110, 4'b0000, 4'b1000, 1));
        tabla.push_back(mk(4'b1100, 4'b1100, XOR_,    4'b0000, 4'b0000, 4'b0100, 1));
        tabla.push_back(mk(4'b0011, 4'b0010, SLL,     4'b1100, 4'b0000, 4'b1000, 1));
        tabla.push_back(mk(4'b0011, 4'b0100, SLL,     4'b0000, 4'b0000, 4'b0100, 1));
        tabla.push_back(mk(4'b1000, 4'b0011, SRL,     4'b0001, 4'b0000, 4'b0000, 1));
        tabla.push_back(mk(4'b1111, 4'b1111, SRL,     4'b0000, 4'b0000, 4'b0100, 1));
        tabla.push_back(mk(4'b0110, 4'b0001, SRA,     4'b0011, 4'b0000, 4'b0000, 1));
        tabla.push_back(mk(4'b0110, 4'b1000, SRA,     4'b0000, 4'b0000, 4'b0100, 1));
        tabla.push_back(mk(4'b0101, 4'b0100, 4'b1111, 4'b1001, 4'b0000, 4'b1001, 1));
        tabla.push_back(mk(4'b0011, 4'b0101, MUL,     4'b1111, 4'b0000, 4'b1000, 5));
        tabla.push_back(mk(4'b1000, 4'b1000, ADD,     4'b0000, 4'b0000, 4'b0111, 1));
        tabla.push_back(mk(4'b0000, 4'b1111, MUL,     4'b0000, 4'b0000, 4'b0100, 5));
        tabla.push_back(mk(4'b0111, 4'b1111, DIV,     4'b0000, 4'b0111, 4'b0100, 5));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_listo", 32'(listo), 32'd1);
        chk("rst_vout", 32'(valido_out), 32'd0);
        chk("rst_res", 32'(resultado), 32'd0);
        chk("rst_alto", 32'(resultado_alto), 32'd0);
        chk("rst_flags", 32'(banderas), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (tabla[i]) run_op(tabla[i].a, tabla[i].b, tabla[i].sel, tabla[i].e);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] ra, rb, rs;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 4'($urandom_range(0, 15));
            run_op(ra, rb, rs, modelo(ra, rb, rs));
        end

        // Backpressure: result held, new requests ignored while waiting
        @(negedge clk);
        operandoA = 4'b0011; operandoB = 4'b0101; seleccion = SUB; valido_in = 1'b1;
        sb.push_back(mk_e(4'b1110, 4'b0000, 4'b1010, 1));
        @(posedge clk); #1; valido_in = 1'b0;
        chk("bp_vout_first", 32'(valido_out), 32'd1);
        got = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            operandoA = 4'b0001; operandoB = 4'b0001; seleccion = ADD;
            valido_in = 1'b1; acepta_in = 1'b0;
            @(posedge clk); #1;
            chk("bp_res", 32'(resultado), 32'(got.res));
            chk("bp_flags", 32'(banderas), 32'(got.flags));
            chk("bp_vout", 32'(valido_out), 32'd1);
            chk("bp_listo", 32'(listo), 32'd0);
        end
        @(negedge clk); valido_in = 1'b0; acepta_in = 1'b1;
        @(posedge clk); #1; acepta_in = 1'b0;
        chk("bp_listo_after", 32'(listo), 32'd1);
        chk("bp_vout_after", 32'(valido_out), 32'd0);
        @(posedge clk); #1;
        chk("bp_no_queue", 32'(valido_out), 32'd0);

        // Reset during a MUL aborts it
        run_op(4'b0011, 4'b0100, ADD, mk_e(4'b0111, 4'b0000, 4'b0000, 1));
        @(negedge clk);
        operandoA = 4'b1101; operandoB = 4'b1011; seleccion = MUL; valido_in = 1'b1;
        @(posedge clk); #1; valido_in = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_res", 32'(resultado), 32'd0);
        chk("abort_alto", 32'(resultado_alto), 32'd0);
        chk("abort_flags", 32'(banderas), 32'd0);
        chk("abort_vout", 32'(valido_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("abort_listo", 32'(listo), 32'd1);
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (valido_out) saw = 1'b1;
        end
        chk("abort_no_result", 32'(saw), 32'd0);

        // Acceptance on the first edge after reset release
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        operandoA = 4'b1000; operandoB = 4'b0101; seleccion = SRA; valido_in = 1'b1;
        sb.push_back(mk_e(4'b1111, 4'b0000, 4'b1000, 1));
        @(posedge clk); #1; valido_in = 1'b0;
        got = sb.pop_front();
        chk("first_edge_vout", 32'(valido_out), 32'd1);
        chk("first_edge_res", 32'(resultado), 32'(got.res));
        chk("first_edge_alto", 32'(resultado_alto), 32'(got.alto));
        chk("first_edge_flags", 32'(banderas), 32'(got.flags));
        @(negedge clk); acepta_in = 1'b1;
        @(posedge clk); #1; acepta_in = 1'b0;
        chk("first_edge_listo", 32'(listo), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
